// File: rtl/fpu_add_align.sv
// Alignment stage of the iterative FPU adder: shifts the smaller-exponent mantissa
// right one bit per cycle (sticky-preserving) until both exponents agree.
module fpu_add_align #(
  parameter int EXP_W      = 10,
  parameter int MAN_W      = 27,
  parameter int FAST_LIMIT = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] a_e,
  input  logic [EXP_W-1:0] b_e,
  input  logic [MAN_W-1:0] a_m,
  input  logic [MAN_W-1:0] b_m,
  input  logic             a_s,
  input  logic             b_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] z_e,
  output logic [MAN_W-1:0] a_m_out,
  output logic [MAN_W-1:0] b_m_out,
  output logic             a_s_out,
  output logic             b_s_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;

  logic signed [EXP_W-1:0] a_e_p0;
  logic signed [EXP_W-1:0] b_e_p0;
  logic        [MAN_W-1:0] a_m_p0;
  logic        [MAN_W-1:0] b_m_p0;
  logic                    a_s_p0;
  logic                    b_s_p0;

  // One-bit right shift; the bit falling off is folded into the sticky LSB.
  function automatic logic [MAN_W-1:0] shift_sticky(input logic [MAN_W-1:0] m);
    logic [MAN_W-1:0] r;
    r    = {1'b0, m[MAN_W-1:1]};
    r[0] = m[0] | m[1];
    return r;
  endfunction

  // Shift distance beyond the mantissa width: only the sticky survives.
  function automatic logic [MAN_W-1:0] collapse_sticky(input logic [MAN_W-1:0] m);
    return {{(MAN_W-1){1'b0}}, |m};
  endfunction

  // Differences carried one bit wider so -2^(EXP_W-1) - (2^(EXP_W-1)-1) cannot wrap.
  logic signed [EXP_W:0] diff_ab;
  logic signed [EXP_W:0] diff_ba;
  logic signed [EXP_W:0] fast_lim;
  logic                  a_gt_b;
  logic                  b_gt_a;
  logic                  fast_ab;
  logic                  fast_ba;

  always_comb begin
    diff_ab  = {a_e_p0[EXP_W-1], a_e_p0} - {b_e_p0[EXP_W-1], b_e_p0};
    diff_ba  = {b_e_p0[EXP_W-1], b_e_p0} - {a_e_p0[EXP_W-1], a_e_p0};
    fast_lim = (EXP_W+1)'(FAST_LIMIT);
    a_gt_b   = diff_ab > 0;
    b_gt_a   = diff_ba > 0;
    fast_ab  = diff_ab >= fast_lim;
    fast_ba  = diff_ba >= fast_lim;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_e_p0    <= '0;
      b_e_p0    <= '0;
      a_m_p0    <= '0;
      b_m_p0    <= '0;
      a_s_p0    <= 1'b0;
      b_s_p0    <= 1'b0;
      z_e       <= '0;
      a_m_out   <= '0;
      b_m_out   <= '0;
      a_s_out   <= 1'b0;
      b_s_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid) begin
            a_e_p0   <= $signed(a_e);
            b_e_p0   <= $signed(b_e);
            a_m_p0   <= a_m;
            b_m_p0   <= b_m;
            a_s_p0   <= a_s;
            b_s_p0   <= b_s;
            in_ready <= 1'b0;
            state    <= ALIGN;
          end
        end

        // One alignment step per cycle; equality publishes the operand set.
        ALIGN: begin
          if (a_gt_b) begin
            if (fast_ab) begin
              b_m_p0 <= collapse_sticky(b_m_p0);
              b_e_p0 <= a_e_p0;
            end else begin
              b_m_p0 <= shift_sticky(b_m_p0);
              b_e_p0 <= b_e_p0 + EXP_W'(1);
            end
          end else if (b_gt_a) begin
            if (fast_ba) begin
              a_m_p0 <= collapse_sticky(a_m_p0);
              a_e_p0 <= b_e_p0;
            end else begin
              a_m_p0 <= shift_sticky(a_m_p0);
              a_e_p0 <= a_e_p0 + EXP_W'(1);
            end
          end else begin
            z_e       <= a_e_p0;
            a_m_out   <= a_m_p0;
            b_m_out   <= b_m_p0;
            a_s_out   <= a_s_p0;
            b_s_out   <= b_s_p0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        // Results held until taken; a new operand is accepted only from IDLE.
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_add_align.sv
// Directed-vector bench for fpu_add_align: latency, alignment, sticky, backpressure, reset.
module tb_fpu_add_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  a_e, b_e;
  logic [26:0] a_m, b_m;
  logic        a_s, b_s;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  z_e;
  logic [26:0] a_m_out, b_m_out;
  logic        a_s_out, b_s_out;

  int checks = 0;
  int passes = 0;

  fpu_add_align #(.EXP_W(10), .MAN_W(27), .FAST_LIMIT(27)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_e(a_e), .b_e(b_e), .a_m(a_m), .b_m(b_m), .a_s(a_s), .b_s(b_s),
    .out_valid(out_valid), .out_ready(out_ready), .z_e(z_e),
    .a_m_out(a_m_out), .b_m_out(b_m_out), .a_s_out(a_s_out), .b_s_out(b_s_out)
  );

  always #5 clk = ~clk;

  // Present one operand set for the accept edge (edge 0), then count edges to out_valid.
  task automatic run_op(input logic [9:0] ae, input logic [9:0] be,
                        input logic [26:0] am, input logic [26:0] bm,
                        input logic as_i, input logic bs_i, output int lat);
    int n;
    a_e = ae; b_e = be; a_m = am; b_m = bm; a_s = as_i; b_s = bs_i;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    lat = out_valid ? n : -1;
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_e = '0; b_e = '0; a_m = '0; b_m = '0; a_s = 1'b0; b_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passes++;
    checks++; if ({z_e, a_m_out, b_m_out, a_s_out, b_s_out} !== '0)
      $display("FAIL reset_data: got z_e=%h a=%h b=%h want 0", z_e, a_m_out, b_m_out); else passes++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_equal_exp();
    int lat;
    run_op(10'd3, 10'd3, 27'h4000000, 27'h6000000, 1'b1, 1'b0, lat);
    checks++; if (lat !== 1) $display("FAIL eq_latency: got %0d want 1", lat); else passes++;
    checks++; if (z_e !== 10'd3) $display("FAIL eq_z_e: got %h want 003", z_e); else passes++;
    checks++; if (a_m_out !== 27'h4000000) $display("FAIL eq_a_m: got %h want 4000000", a_m_out); else passes++;
    checks++; if (b_m_out !== 27'h6000000) $display("FAIL eq_b_m: got %h want 6000000", b_m_out); else passes++;
    checks++; if ({a_s_out, b_s_out} !== 2'b10) $display("FAIL eq_signs: got %b want 10", {a_s_out, b_s_out}); else passes++;
    checks++; if (in_ready !== 1'b0) $display("FAIL eq_in_ready_done: got %b want 0", in_ready); else passes++;
    take_output();
    checks++; if (in_ready !== 1'b1) $display("FAIL eq_in_ready_idle: got %b want 1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL eq_out_valid_drop: got %b want 0", out_valid); else passes++;
  endtask

  task automatic test_a_larger();
    int lat;
    run_op(10'd5, 10'd2, 27'h1234567, 27'h4000007, 1'b0, 1'b1, lat);
    checks++; if (lat !== 4) $display("FAIL alarger_latency: got %0d want 4", lat); else passes++;
    checks++; if (z_e !== 10'd5) $display("FAIL alarger_z_e: got %h want 005", z_e); else passes++;
    checks++; if (b_m_out !== 27'h0800001) $display("FAIL alarger_b_m: got %h want 0800001", b_m_out); else passes++;
    checks++; if (a_m_out !== 27'h1234567) $display("FAIL alarger_a_m: got %h want 1234567", a_m_out); else passes++;
    checks++; if ({a_s_out, b_s_out} !== 2'b01) $display("FAIL alarger_signs: got %b want 01", {a_s_out, b_s_out}); else passes++;
    take_output();
  endtask

  task automatic test_b_larger_neg();
    int lat;
    run_op(10'h382, 10'h384, 27'h0000004, 27'h2AAAAAA, 1'b1, 1'b1, lat);
    checks++; if (lat !== 3) $display("FAIL bneg_latency: got %0d want 3", lat); else passes++;
    checks++; if (z_e !== 10'h384) $display("FAIL bneg_z_e: got %h want 384", z_e); else passes++;
    checks++; if (a_m_out !== 27'h0000001) $display("FAIL bneg_a_m: got %h want 0000001", a_m_out); else passes++;
    checks++; if (b_m_out !== 27'h2AAAAAA) $display("FAIL bneg_b_m: got %h want 2aaaaaa", b_m_out); else passes++;
    take_output();
  endtask

  task automatic test_fast_collapse();
    int lat;
    run_op(10'd100, 10'h3EC, 27'h0000010, 27'h4000000, 1'b0, 1'b0, lat);
    checks++; if (lat !== 2) $display("FAIL fast_latency: got %0d want 2", lat); else passes++;
    checks++; if (z_e !== 10'd100) $display("FAIL fast_z_e: got %h want 064", z_e); else passes++;
    checks++; if (b_m_out !== 27'h0000001) $display("FAIL fast_b_m: got %h want 0000001", b_m_out); else passes++;
    take_output();
    run_op(10'd100, 10'h3EC, 27'h0000010, 27'h0000000, 1'b0, 1'b0, lat);
    checks++; if (b_m_out !== 27'h0000000) $display("FAIL fast_zero_b_m: got %h want 0000000", b_m_out); else passes++;
    take_output();
    // Extremes of the exponent range: -127 vs 127, b wins.
    run_op(10'h381, 10'h07F, 27'h7FFFFFF, 27'h0000123, 1'b1, 1'b0, lat);
    checks++; if (lat !== 2) $display("FAIL extreme_latency: got %0d want 2", lat); else passes++;
    checks++; if (z_e !== 10'h07F) $display("FAIL extreme_z_e: got %h want 07f", z_e); else passes++;
    checks++; if (a_m_out !== 27'h0000001) $display("FAIL extreme_a_m: got %h want 0000001", a_m_out); else passes++;
    take_output();
  endtask

  task automatic test_limit_boundary();
    int lat;
    // d=26 walks bit by bit: MSB lands exactly in bit0.
    run_op(10'd26, 10'd0, 27'h0000000, 27'h4000000, 1'b0, 1'b0, lat);
    checks++; if (lat !== 27) $display("FAIL d26_latency: got %0d want 27", lat); else passes++;
    checks++; if (b_m_out !== 27'h0000001) $display("FAIL d26_b_m: got %h want 0000001", b_m_out); else passes++;
    take_output();
    run_op(10'd27, 10'd0, 27'h0000000, 27'h4000000, 1'b0, 1'b0, lat);
    checks++; if (lat !== 2) $display("FAIL d27_latency: got %0d want 2", lat); else passes++;
    checks++; if (b_m_out !== 27'h0000001) $display("FAIL d27_b_m: got %h want 0000001", b_m_out); else passes++;
    take_output();
    // Sticky-only mantissa survives repeated shifts; zero stays zero.
    run_op(10'd0, 10'd12, 27'h0000001, 27'h0000005, 1'b0, 1'b0, lat);
    checks++; if (lat !== 13) $display("FAIL sticky_latency: got %0d want 13", lat); else passes++;
    checks++; if (a_m_out !== 27'h0000001) $display("FAIL sticky_a_m: got %h want 0000001", a_m_out); else passes++;
    take_output();
    run_op(10'd7, 10'd0, 27'h0000002, 27'h0000000, 1'b0, 1'b0, lat);
    checks++; if (b_m_out !== 27'h0000000) $display("FAIL zero_shift_b_m: got %h want 0000000", b_m_out); else passes++;
    take_output();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(10'd4, 10'd1, 27'h3000000, 27'h0000008, 1'b1, 1'b0, lat);
    checks++; if (b_m_out !== 27'h0000001) $display("FAIL bp_initial_b_m: got %h want 0000001", b_m_out); else passes++;
    for (int i = 0; i < 5; i++) begin
      a_e = 10'(i); b_e = 10'(i); a_m = 27'h1111111 * 27'(i + 1); b_m = 27'h0F0F0F0; a_s = 1'b0; b_s = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); else passes++;
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); else passes++;
      checks++; if ({z_e, a_m_out, b_m_out, a_s_out, b_s_out} !== {10'd4, 27'h3000000, 27'h0000001, 1'b1, 1'b0})
        $display("FAIL bp_hold[%0d]: got z_e=%h a=%h b=%h want 004/3000000/0000001", i, z_e, a_m_out, b_m_out);
      else passes++;
    end
    in_valid = 1'b0;
    take_output();
    checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready: got %b want 1", in_ready); else passes++;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_no_capture: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); else passes++;
  endtask

  task automatic test_reset_mid_align();
    int lat;
    a_e = 10'd10; b_e = 10'd0; a_m = 27'h0000000; b_m = 27'h7FFFFFF; a_s = 1'b1; b_s = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", in_ready); else passes++;
    checks++; if ({out_valid, z_e, a_m_out, b_m_out, a_s_out, b_s_out} !== '0)
      $display("FAIL rstmid_outputs: got v=%b z_e=%h a=%h b=%h want 0", out_valid, z_e, a_m_out, b_m_out); else passes++;
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(10'h3F0, 10'h3F0, 27'h0ABCDEF, 27'h1000000, 1'b0, 1'b1, lat);
    checks++; if (lat !== 1) $display("FAIL rstmid_new_latency: got %0d want 1", lat); else passes++;
    checks++; if ({z_e, a_m_out, b_m_out} !== {10'h3F0, 27'h0ABCDEF, 27'h1000000})
      $display("FAIL rstmid_new_data: got z_e=%h a=%h b=%h want 3f0/0abcdef/1000000", z_e, a_m_out, b_m_out); else passes++;
    take_output();
  endtask

  initial begin
    test_reset();
    test_equal_exp();
    test_a_larger();
    test_b_larger_neg();
    test_fast_collapse();
    test_limit_boundary();
    test_backpressure();
    test_reset_mid_align();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
